mux8_scan_seq: RTL and testbench

//   Scan sequencer that sits directly upstream of the 8:1 mux (mux8).

---
 rtl/mux8_scan_seq.sv | 118 +++++++++++
 tb/tb_mux8_scan_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_scan_seq.sv
// rtl/mux8_scan_seq.sv - scan sequencer driving mux8 selects and assembling the sampled word
module mux8_scan_seq #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic       y,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     r_state;
    logic [7:0] r_mask;
    logic [7:0] r_shadow;
    logic [7:0] r_data;
    logic [2:0] r_sel;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;

    logic [7:0] w_higher;
    logic [7:0] w_shadow_smp;

    function automatic logic [2:0] f_lowest(input logic [7:0] v);
        f_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) f_lowest = 3'(i);
        end
    endfunction

    // Enabled channels strictly above the current select, so masked ones are skipped
    assign w_higher = r_mask & (8'hFE << r_sel);

    always_comb begin
        w_shadow_smp        = r_shadow;
        w_shadow_smp[r_sel] = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mask   <= 8'h00;
            r_shadow <= 8'h00;
            r_data   <= 8'h00;
            r_sel    <= 3'd0;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mask   <= mask;
                        r_shadow <= 8'h00;
                        if (mask == 8'h00) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_data  <= 8'h00;
                        end else begin
                            r_state <= HOLD;
                            r_sel   <= f_lowest(mask);
                            r_cnt   <= CNT_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == 4'd0) begin
                        r_shadow <= w_shadow_smp;
                        if (|w_higher) begin
                            r_sel <= f_lowest(w_higher);
                            r_cnt <= CNT_LOAD;
                        end else begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_sel   <= 3'd0;
                            r_done  <= 1'b1;
                            r_data  <= w_shadow_smp;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_sel   <= 3'd0;
                end
            endcase
        end
    end

    assign s0   = r_sel[0];
    assign s1   = r_sel[1];
    assign s2   = r_sel[2];
    assign busy = r_busy;
    assign done = r_done;
    assign data = r_data;
endmodule

// File: tb/tb_mux8_scan_seq.sv
// tb/tb_mux8_scan_seq.sv - directed bench for mux8_scan_seq with SETTLE=1 and SETTLE=2 instances
module tb_mux8_scan_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] mask;
    logic [7:0] a1, a2;
    logic       y1, y2;
    logic       s0_1, s1_1, s2_1, busy1, done1;
    logic       s0_2, s1_2, s2_2, busy2, done2;
    logic [7:0] data1, data2;
    logic [2:0] sel1, sel2;

    int n_tests = 0;
    int n_fail  = 0;

    mux8_scan_seq #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .y(y1),
        .s0(s0_1), .s1(s1_1), .s2(s2_1), .busy(busy1), .done(done1), .data(data1)
    );

    mux8_scan_seq #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .y(y2),
        .s0(s0_2), .s1(s1_2), .s2(s2_2), .busy(busy2), .done(done2), .data(data2)
    );

    assign sel1 = {s2_1, s1_1, s0_1};
    assign sel2 = {s2_2, s1_2, s0_2};
    assign y1   = a1[sel1];
    assign y2   = a2[sel2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        mask  = 8'h00;
        a1    = 8'h00;
        a2    = 8'h00;
        #12;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_sel", sel1, 0);
        check("rst_data", data1, 8'h00);
        rst_n = 1'b1;
        idle(2);

        // 1: SETTLE=1, all channels, inputs A6
        a1 = 8'hA6; mask = 8'hFF; start = 1'b1;
        step(); start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("t1_sel_c%0d", c), sel1, c - 1);
            check($sformatf("t1_busy_c%0d", c), busy1, 1);
            check($sformatf("t1_done_c%0d", c), done1, 0);
            step();
        end
        check("t1_done", done1, 1);
        check("t1_data", data1, 8'hA6);
        check("t1_busy_done", busy1, 0);
        check("t1_sel_done", sel1, 0);
        step();
        check("t1_done_pulse", done1, 0);
        check("t1_data_hold", data1, 8'hA6);
        idle(20);

        // 2: SETTLE=2, mask 81, all inputs 1
        a2 = 8'hFF; mask = 8'h81; start = 1'b1;
        step(); start = 1'b0;
        check("t2_sel_c1", sel2, 0);
        step();
        check("t2_sel_c2", sel2, 0);
        check("t2_busy_c2", busy2, 1);
        step();
        check("t2_sel_c3", sel2, 7);
        step();
        check("t2_sel_c4", sel2, 7);
        check("t2_done_c4", done2, 0);
        step();
        check("t2_done_c5", done2, 1);
        check("t2_data", data2, 8'h81);
        idle(20);

        // 3: empty mask
        mask = 8'h00; start = 1'b1;
        step(); start = 1'b0;
        check("t3_done", done1, 1);
        check("t3_data", data1, 8'h00);
        check("t3_busy", busy1, 0);
        check("t3_sel", sel1, 0);
        check("t3_data2", data2, 8'h00);
        step();
        check("t3_busy_c2", busy1, 0);
        idle(20);

        // 4: start held high, mask 03
        a1 = 8'hFF; mask = 8'h03; start = 1'b1;
        step();
        check("t4_busy_c1", busy1, 1);
        step();
        check("t4_sel_c2", sel1, 1);
        step();
        check("t4_done_c3", done1, 1);
        check("t4_data_c3", data1, 8'h03);
        step();
        check("t4_busy_c4", busy1, 0);
        check("t4_done_c4", done1, 0);
        step();
        check("t4_busy_c5", busy1, 1);
        check("t4_sel_c5", sel1, 0);
        idle(40);

        // 5: mask change during scan is ignored
        a1 = 8'hFF; mask = 8'h0F; start = 1'b1;
        step(); start = 1'b0;
        step(); mask = 8'hF0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (done1) seen = 1;
            else step();
        end
        check("t5_done_seen", seen, 1);
        check("t5_data", data1, 8'h0F);
        idle(20);

        // 6: reset mid-scan, then a clean scan
        a1 = 8'hFF; mask = 8'hFF; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy_rst", busy1, 0);
        check("t6_sel_rst", sel1, 0);
        check("t6_data_rst", data1, 8'h00);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done1) seen = 1;
        end
        check("t6_no_done", seen, 0);
        #2 rst_n = 1'b1;
        step();
        a1 = 8'h04; mask = 8'h05; start = 1'b1;
        step(); start = 1'b0;
        check("t6_sel_c1", sel1, 0);
        step();
        check("t6_sel_c2", sel1, 2);
        step();
        check("t6_done_c3", done1, 1);
        check("t6_data_c3", data1, 8'h04);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
